// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared encodings, widths and defaults for the VGA scene sequencer
package vga_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_t;

  localparam int SPEED_W             = 2;
  localparam int SCROLL_W            = 10;
  localparam int FCNT_W              = 10;
  localparam int PAT_W               = 2;
  localparam int DEFAULT_AUTO_FRAMES = 120;
  localparam int DEFAULT_N_PATTERNS  = 4;

  function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] cur,
                                                    input int               n_patterns);
    if (int'(cur) >= n_patterns - 1) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/frame_button_filter.sv
// rtl/frame_button_filter.sv - per-frame button history with a single press event per held press
module frame_button_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic press
);

  // The live sample plus two stored frame samples form the 3-deep window;
  // hist[0] is the previous frame, hist[1] the one before.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (en) begin
      hist <= {hist[0], btn};
    end
  end

  // Newest-to-oldest 1,1,0: fires once on the second held frame, ignores 1-frame glitches.
  assign press = en & btn & hist[0] & ~hist[1];

endmodule

// File: rtl/vga_scene_sequencer.sv
// rtl/vga_scene_sequencer.sv - frame-synchronous pattern, scroll and speed sequencer for the VGA pattern datapath
module vga_scene_sequencer
  import vga_ctrl_pkg::*;
#(
  parameter int AUTO_FRAMES = DEFAULT_AUTO_FRAMES,
  parameter int N_PATTERNS  = DEFAULT_N_PATTERNS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                btn_next,
  input  logic                btn_pause,
  input  logic                btn_speed,
  input  logic                auto_en,
  output logic [SCROLL_W-1:0] scroll_x,
  output logic [PAT_W-1:0]    pattern_sel,
  output logic [SPEED_W-1:0]  speed_idx,
  output logic                paused,
  output logic                frame_tick
);

  logic              vsync_q;
  logic              vsync_armed;
  logic              next_ev;
  logic              pause_ev;
  logic              speed_ev;
  logic              auto_expire;
  logic [FCNT_W-1:0] frame_cnt;
  logic [SCROLL_W-1:0] step;
  run_state_t        state;
  run_state_t        state_nxt;

  // vsync_armed blocks a tick until vsync has been seen high after reset,
  // so a vsync held low through reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      vsync_armed <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      vsync_armed <= vsync_armed | vsync;
      frame_tick  <= vsync_armed & vsync_q & ~vsync;
    end
  end

  frame_button_filter u_next_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (frame_tick),
    .btn   (btn_next),
    .press (next_ev)
  );

  frame_button_filter u_pause_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (frame_tick),
    .btn   (btn_pause),
    .press (pause_ev)
  );

  frame_button_filter u_speed_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (frame_tick),
    .btn   (btn_speed),
    .press (speed_ev)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pause_ev) begin
      state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always_comb begin
    paused = (state == ST_PAUSE);
  end

  assign step        = SCROLL_W'(1) << speed_idx;
  assign auto_expire = auto_en && (state == ST_RUN) && (frame_cnt == FCNT_W'(AUTO_FRAMES - 1));

  // Scroll and expiry use the pre-event state and speed of this frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll_x    <= '0;
      pattern_sel <= '0;
      speed_idx   <= '0;
      frame_cnt   <= '0;
    end else if (frame_tick) begin
      if (state == ST_RUN) begin
        scroll_x <= scroll_x + step;
      end
      if (speed_ev) begin
        speed_idx <= speed_idx + 1'b1;
      end
      if (next_ev || auto_expire) begin
        pattern_sel <= next_pattern(pattern_sel, N_PATTERNS);
      end
      if (!auto_en || next_ev || auto_expire) begin
        frame_cnt <= '0;
      end else if (state == ST_RUN) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/vga_scene_sequencer.md
VGA_SCENE_SEQUENCER -- requirements
Module: vga_scene_sequencer

Interface
REQ-001 Parameter AUTO_FRAMES, default 120, gives the number of frames per pattern in auto mode (range 2..1023).
REQ-002 Parameter N_PATTERNS, default 4, gives the number of selectable patterns (range 2..4).
REQ-003 clk  input  1  pixel clock; the only clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 vsync  input  1  active-low vertical sync from the sync generator, same clock domain.
REQ-006 btn_next  input  1  level button; advances the pattern.
REQ-007 btn_pause  input  1  level button; toggles run/pause.
REQ-008 btn_speed  input  1  level button; cycles the scroll speed.
REQ-009 auto_en  input  1  level; enables auto pattern cycling.
REQ-010 scroll_x  output  10  horizontal scroll offset for the pattern datapath.
REQ-011 pattern_sel  output  2  active pattern index.
REQ-012 speed_idx  output  2  speed code; step = 1 << speed_idx.
REQ-013 paused  output  1  high in PAUSE state.
REQ-014 frame_tick  output  1  one-cycle pulse per frame boundary.

Function
REQ-015 Frame boundary: frame_tick SHALL pulse high for exactly one cycle, in the cycle after vsync is first sampled low following a sampled high; a held-low vsync SHALL NOT retrigger.
REQ-016 All state (scroll_x, pattern_sel, speed_idx, paused, counters, button histories) SHALL change only on the clock edge that ends a frame_tick cycle, so outputs are stable for a whole frame.
REQ-017 Buttons SHALL be sampled only at frame_tick, into a 3-deep history per button.
REQ-018 A press event SHALL be generated when the history reads newest-to-oldest 1,1,0, so exactly one event fires per press held for at least 2 frames; 1-frame glitches SHALL be ignored.
REQ-019 The FSM SHALL have two states, RUN and PAUSE; a btn_pause event SHALL toggle the state.
REQ-020 In RUN, scroll_x SHALL advance by 1 << speed_idx each frame, modulo 1024, wrapping 1023+1 to 0 and 1020+8 to 4.
REQ-021 In PAUSE, scroll_x and the auto frame counter SHALL hold; btn_next and btn_speed events SHALL still take effect.
REQ-022 A btn_speed event SHALL increment speed_idx modulo 4 (3 wraps to 0); the new step SHALL apply from the next frame.
REQ-023 A btn_next event SHALL set pattern_sel to (pattern_sel+1) mod N_PATTERNS and clear the auto frame counter.
REQ-024 Auto mode (auto_en=1, RUN): the frame counter SHALL count frames 0..AUTO_FRAMES-1; on the frame where it equals AUTO_FRAMES-1, pattern_sel SHALL advance as in REQ-023 and the counter SHALL return to 0.
REQ-025 If auto_en=0, the frame counter SHALL be held at 0.
REQ-026 Simultaneous btn_next event and auto expiry in one frame SHALL advance pattern_sel by exactly one.
REQ-027 Simultaneous btn_pause and btn_speed events SHALL both take effect. Scroll in that frame SHALL use the pre-event state and speed.
REQ-028 paused SHALL equal (state == PAUSE).

Reset
REQ-029 While rst_n is sampled low, at the next clock edge: scroll_x=0, pattern_sel=0, speed_idx=0, paused=0 (RUN), frame_tick=0, frame counter=0, button histories=0, vsync history=1.
REQ-030 Reset SHALL take effect mid-frame without waiting for frame_tick; the first frame_tick after release SHALL require a fresh high-to-low vsync transition.

Structure
REQ-031 Shared package vga_ctrl_pkg SHALL hold the RUN/PAUSE state encoding, the speed code width, and the default AUTO_FRAMES and N_PATTERNS constants.
REQ-032 Sub-module frame_button_filter (history register plus press-event output, enabled by frame_tick) SHALL be instantiated three times.
REQ-033 The block SHALL contain no combinational path from any button input to any output.

Verification
REQ-034 Reset, then 3 vsync falling edges with no buttons pressed -> scroll_x=3, exactly 3 frame_tick pulses, pattern_sel=0.
REQ-035 btn_speed held 5 frames, then released -> speed_idx becomes 1 at the 2nd frame and no further events; next frames step scroll_x by 2.
REQ-036 scroll_x=1020 with speed_idx=3 in RUN, one frame -> scroll_x=4.
REQ-037 auto_en=1, AUTO_FRAMES=4, N_PATTERNS=3 -> pattern_sel goes 0,1,2,0 every 4 frames; a btn_next event on the expiry frame gives a single +1 advance.
REQ-038 btn_pause event, then 10 frames -> paused=1 and scroll_x frozen; a btn_next event during pause still advances pattern_sel.
REQ-039 rst_n low for 1 cycle mid-frame with vsync held low -> all outputs zero next cycle, no frame_tick until vsync goes high and then low again.
